// File: rtl/wb_stage_if.sv
// wb_stage_if: bundles the memory-stage handshake, register-file write
// port and forwarding tap of the write-back stage.
// master: the upstream/observing side (memory stage, register file, hazard unit).
// slave : the write-back stage itself.
interface wb_stage_if #(
    parameter int BUS_WIDTH      = 64,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      mem_read;
    logic                      reg_write;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [BUS_WIDTH-1:0]      write_data;
    logic [BUS_WIDTH-1:0]      mem_out;
    logic                      flush;
    logic                      rf_we;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr;
    logic [BUS_WIDTH-1:0]      rf_wdata;
    logic                      stall;
    logic                      fwd_valid;
    logic [REG_ADDR_WIDTH-1:0] fwd_rd;
    logic [BUS_WIDTH-1:0]      fwd_data;

    modport master (
        output in_valid, mem_read, reg_write, rd, write_data, mem_out, flush,
        input  in_ready, rf_we, rf_waddr, rf_wdata, stall,
               fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  in_valid, mem_read, reg_write, rd, write_data, mem_out, flush,
        output in_ready, rf_we, rf_waddr, rf_wdata, stall,
               fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Retires one instruction per handshake,
// waits out the fixed data-memory read latency on loads, and drives the
// register-file write port with a one-cycle commit pulse.
// Optional feature macro: WB_FWD_EN exposes a WB->EX forwarding tap that
// mirrors the register-file write port; undefined ties the tap to zero.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready to accept; non-loads retire here one per cycle
// LOAD_WAIT | load outstanding; counter runs down to the data capture
module wb_stage #(
    parameter int BUS_WIDTH      = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LOAD_LATENCY   = 2
) (
    input logic         clk,
    input logic         rst,
    wb_stage_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    // Counter starts at LOAD_LATENCY-1 so the capture lands on edge T+LOAD_LATENCY.
    localparam logic [2:0] LAT_M1 = 3'(LOAD_LATENCY - 1);

    state_t                    state;
    logic [2:0]                count;
    logic                      in_ready_q;
    logic [REG_ADDR_WIDTH-1:0] pend_rd;
    logic                      pend_we;
    logic                      rf_we_q;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_q;
    logic [BUS_WIDTH-1:0]      rf_wdata_q;
    logic                      accept;

    // in_ready_q is high only in IDLE, so accept implies IDLE.
    assign accept = bus.in_valid & in_ready_q & ~bus.flush;

    // Sequencer: accept, load wait, commit pulse and flush handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 3'd0;
            in_ready_q <= 1'b1;
            pend_rd    <= '0;
            pend_we    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.mem_read) begin
                            pend_rd    <= bus.rd;
                            pend_we    <= bus.reg_write;
                            count      <= LAT_M1;
                            state      <= LOAD_WAIT;
                            in_ready_q <= 1'b0;
                        end else begin
                            rf_we_q <= bus.reg_write & (bus.rd != '0);
                            // Port holds its last value unless a write is issued;
                            // an x0 write still updates it (value is a don't-care).
                            if (bus.reg_write) begin
                                rf_waddr_q <= bus.rd;
                                rf_wdata_q <= bus.write_data;
                            end
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (bus.flush) begin
                        // Flush beats the capture edge: the load is dropped.
                        state      <= IDLE;
                        count      <= 3'd0;
                        in_ready_q <= 1'b1;
                    end else if (count != 3'd0) begin
                        count <= count - 3'd1;
                    end else begin
                        rf_we_q <= pend_we & (pend_rd != '0);
                        if (pend_we) begin
                            rf_waddr_q <= pend_rd;
                            rf_wdata_q <= bus.mem_out;
                        end
                        state      <= IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    count      <= 3'd0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.stall    = ~in_ready_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

`ifdef WB_FWD_EN
    assign bus.fwd_valid = rf_we_q;
    assign bus.fwd_rd    = rf_waddr_q;
    assign bus.fwd_data  = rf_wdata_q;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_rd    = '0;
    assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage. Expected commits (rd, data,
// cycle) are queued when an instruction is driven and popped by a
// negedge monitor whenever rf_we rises.
module tb_wb_stage;
    localparam int BW = 64;
    localparam int AW = 5;
    localparam int LL = 2;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [BW-1:0] data;
        logic [31:0]   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if #(.BUS_WIDTH(BW), .REG_ADDR_WIDTH(AW)) bus ();

    wb_stage #(.BUS_WIDTH(BW), .REG_ADDR_WIDTH(AW), .LOAD_LATENCY(LL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cyc      = 0;
    bit          mon_en   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: stall/forwarding invariants every cycle, commits against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (bus.stall !== ~bus.in_ready) begin
                n_fail++;
                $display("FAIL stall: got %b, want %b", bus.stall, ~bus.in_ready);
            end
            n_checks++;
`ifdef WB_FWD_EN
            if (bus.fwd_valid !== bus.rf_we || bus.fwd_rd !== bus.rf_waddr || bus.fwd_data !== bus.rf_wdata) begin
                n_fail++;
                $display("FAIL fwd_mirror: got %b/%0d/%h, want %b/%0d/%h", bus.fwd_valid, bus.fwd_rd,
                         bus.fwd_data, bus.rf_we, bus.rf_waddr, bus.rf_wdata);
            end
`else
            if (bus.fwd_valid !== 1'b0 || bus.fwd_rd !== '0 || bus.fwd_data !== '0) begin
                n_fail++;
                $display("FAIL fwd_zero: got %b/%0d/%h, want 0/0/0", bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
            end
`endif
            if (bus.rf_we !== 1'b0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_commit: got rf_we=%b rd=%0d data=%h at cyc %0d, want no commit",
                             bus.rf_we, bus.rf_waddr, bus.rf_wdata, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== mon_e.rd ||
                        bus.rf_wdata !== mon_e.data || cyc !== mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL commit: got rd=%0d data=%h cyc=%0d, want rd=%0d data=%h cyc=%0d",
                                 bus.rf_waddr, bus.rf_wdata, cyc, mon_e.rd, mon_e.data, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish by 200000, want finish");
        $fatal(1);
    end

    task automatic set_idle();
        bus.in_valid   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.rd         = '0;
        bus.write_data = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a non-load; returns just after the accepting edge.
    task automatic issue_nl(input logic rw, input logic [AW-1:0] r, input logic [BW-1:0] d);
        bus.in_valid   = 1'b1;
        bus.mem_read   = 1'b0;
        bus.reg_write  = rw;
        bus.rd         = r;
        bus.write_data = d;
        bus.flush      = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL nl_ready: got in_ready=%b, want 1", bus.in_ready);
        end
        step();
        if (rw && r != '0) sb.push_back(exp_t'{r, d, cyc});
    endtask

    // Offer a load; mem_out carries the real data only in the cycle before edge T+LL.
    task automatic issue_ld(input logic rw, input logic [AW-1:0] r, input logic [BW-1:0] val);
        logic [31:0] acc;
        bus.in_valid  = 1'b1;
        bus.mem_read  = 1'b1;
        bus.reg_write = rw;
        bus.rd        = r;
        bus.flush     = 1'b0;
        bus.mem_out   = ~val;
        step();
        acc = cyc;
        set_idle();
        for (int i = 0; i < LL; i++) begin
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ld_busy: got in_ready=%b at wait cycle %0d, want 0", bus.in_ready, i);
            end
            bus.mem_out = (i == LL - 1) ? val : ~val;
            if (i < LL - 1) step();
        end
        if (rw && r != '0) sb.push_back(exp_t'{r, val, acc + LL});
        step();
        bus.mem_out = ~val;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_done_ready: got in_ready=%b, want 1", bus.in_ready);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending commits, want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        bus.mem_out = '0;
        step();
        step();
        rst = 1'b0;
        mon_en = 1;
        step();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.stall !== 1'b0 || bus.rf_we !== 1'b0 ||
            bus.rf_waddr !== '0 || bus.rf_wdata !== '0 || bus.fwd_valid !== 1'b0 ||
            bus.fwd_rd !== '0 || bus.fwd_data !== '0) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b stall=%b we=%b wa=%0d wd=%h fv=%b, want 1 0 0 0 0 0",
                     bus.in_ready, bus.stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fwd_valid);
        end
        step();
    endtask

    task automatic test_non_load();
        issue_nl(1'b1, 5'd5, 64'h1234);
        set_idle();
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 64'h1234) begin
            n_fail++;
            $display("FAIL nl_commit: got %b/%0d/%h, want 1/5/1234", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        step();
        n_checks++;
        if (bus.rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL nl_pulse: got rf_we=%b one cycle later, want 0", bus.rf_we);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] d;
        issue_nl(1'b1, 5'd5, 64'h1234);
        issue_nl(1'b1, 5'd6, 64'h5678);
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            issue_nl(1'b1, 5'(8 + i), d);
        end
        set_idle();
        wait_drain();
        step();
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd11 || bus.rf_wdata !== d) begin
            n_fail++;
            $display("FAIL hold: got %b/%0d/%h, want 0/11/%h", bus.rf_we, bus.rf_waddr, bus.rf_wdata, d);
        end
    endtask

    task automatic test_load();
        issue_ld(1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80);
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
            n_fail++;
            $display("FAIL ld_commit: got %b/%0d/%h, want 1/7/ffffffffffffff80",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        issue_ld(1'b1, 5'd12, 64'h0000_0000_0000_00AB);
        issue_nl(1'b1, 5'd13, 64'hCAFE);
        set_idle();
        wait_drain();
    endtask

    task automatic test_x0();
        issue_nl(1'b1, 5'd0, 64'hDEAD);
        issue_nl(1'b0, 5'd3, 64'hBEEF);
        set_idle();
        n_checks++;
        if (bus.rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL no_write: got rf_we=%b, want 0", bus.rf_we);
        end
        issue_ld(1'b1, 5'd0, 64'h77);
        step();
        wait_drain();
    endtask

    task automatic test_flush();
        // Flush on the first wait edge.
        bus.in_valid = 1'b1; bus.mem_read = 1'b1; bus.reg_write = 1'b1; bus.rd = 5'd7;
        bus.mem_out = 64'h55;
        step();
        set_idle();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: got in_ready=%b, want 1", bus.in_ready);
        end
        repeat (4) step();
        // Flush on the capture edge.
        bus.in_valid = 1'b1; bus.mem_read = 1'b1; bus.reg_write = 1'b1; bus.rd = 5'd8;
        step();
        set_idle();
        for (int i = 0; i < LL - 1; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_capture: got in_ready=%b rf_we=%b, want 1 0", bus.in_ready, bus.rf_we);
        end
        // Flush together with in_valid.
        bus.in_valid = 1'b1; bus.reg_write = 1'b1; bus.rd = 5'd9; bus.write_data = 64'h99;
        bus.flush = 1'b1;
        step();
        set_idle();
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_valid: got rf_we=%b in_ready=%b, want 0 1", bus.rf_we, bus.in_ready);
        end
        repeat (3) step();
        issue_nl(1'b1, 5'd10, 64'hA5A5);
        set_idle();
        wait_drain();
    endtask

    task automatic test_reset_mid_load();
        bus.in_valid = 1'b1; bus.mem_read = 1'b1; bus.reg_write = 1'b1; bus.rd = 5'd14;
        bus.mem_out = 64'h1111;
        step();
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.stall !== 1'b0 || bus.rf_we !== 1'b0 ||
            bus.rf_waddr !== '0 || bus.rf_wdata !== '0 || bus.fwd_valid !== 1'b0 ||
            bus.fwd_rd !== '0 || bus.fwd_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b stall=%b we=%b wa=%0d wd=%h fv=%b, want 1 0 0 0 0 0",
                     bus.in_ready, bus.stall, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.fwd_valid);
        end
        repeat (4) step();
        n_checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_drop: got rf_we=%b rf_waddr=%0d, want 0 0", bus.rf_we, bus.rf_waddr);
        end
    endtask

    initial begin
        test_reset();
        test_non_load();
        test_back_to_back();
        test_load();
        test_x0();
        test_flush();
        test_reset_mid_load();
        wait_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
